mult4_seq_ctrl: RTL and testbench

MULT4_SEQ_CTRL -- requirements
Module: mult4_seq_ctrl

---
 rtl/mult4_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_mult4_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult4_seq_ctrl.sv
// Sequential 4x4 multiplier controller driving a shared external 2x2 multiplier
// over four partial-product cycles. Optional result checker: MULT4_SEQ_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for an operand request
// LL    | a[1:0] x b[1:0], weight 1
// LH    | a[1:0] x b[3:2], weight 4
// HL    | a[3:2] x b[1:0], weight 4
// HH    | a[3:2] x b[3:2], weight 16
// DONE  | product presented, held until out_ready
module mult4_seq_ctrl #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] p,
  output logic [1:0]       pp_a,
  output logic [1:0]       pp_b,
  input  logic [3:0]       pp_p,
  output logic             busy
`ifdef MULT4_SEQ_CHECK_EN
  ,
  output logic             err,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LL,
    S_LH,
    S_HL,
    S_HH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] pp_ext;

  assign pp_ext = ACC_W'(pp_p);
  assign p      = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    pp_a      = 2'b00;
    pp_b      = 2'b00;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_LL: begin
        busy    = 1'b1;
        pp_a    = a_q[1:0];
        pp_b    = b_q[1:0];
        acc_d   = acc_q + pp_ext;
        state_d = S_LH;
      end
      S_LH: begin
        busy    = 1'b1;
        pp_a    = a_q[1:0];
        pp_b    = b_q[3:2];
        acc_d   = acc_q + (pp_ext << 2);
        state_d = S_HL;
      end
      S_HL: begin
        busy    = 1'b1;
        pp_a    = a_q[3:2];
        pp_b    = b_q[1:0];
        acc_d   = acc_q + (pp_ext << 2);
        state_d = S_HH;
      end
      S_HH: begin
        busy    = 1'b1;
        pp_a    = a_q[3:2];
        pp_b    = b_q[3:2];
        acc_d   = acc_q + (pp_ext << 4);
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Accept overrides the DONE->IDLE exit so back-to-back requests see no gap.
    if (in_valid && in_ready) begin
      a_d     = a;
      b_d     = b;
      acc_d   = '0;
      state_d = S_LL;
    end
  end

`ifdef MULT4_SEQ_CHECK_EN
  logic [7:0] exact_prod;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign exact_prod = {4'b0000, a_q} * {4'b0000, b_q};
  assign err        = out_valid && (acc_q != ACC_W'(exact_prod));
  assign err_cnt    = err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err && out_ready && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end
`endif

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Self-checking bench for mult4_seq_ctrl: directed cases plus randomized
// transactions against an arithmetic model of the approximate 2x2 multiplier.
module tb_mult4_seq_ctrl;
  localparam int ACC_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] p;
  logic [1:0]       pp_a;
  logic [1:0]       pp_b;
  logic [3:0]       pp_p;
  logic             busy;
`ifdef MULT4_SEQ_CHECK_EN
  logic             err;
  logic [7:0]       err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int pp_mode = 0;
  int last_exp = 0;
  int exp_cnt = 0;
  bit pend_err = 1'b0;
  bit in_done = 1'b0;

  always #5 clk = ~clk;

  mult4_seq_ctrl #(.ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p(p),
    .pp_a(pp_a),
    .pp_b(pp_b),
    .pp_p(pp_p),
    .busy(busy)
`ifdef MULT4_SEQ_CHECK_EN
    ,
    .err(err),
    .err_cnt(err_cnt)
`endif
  );

  // mode 0: exact, 1: 3x3 returns 7, 2: always 15
  function automatic logic [3:0] pp_fn(input logic [1:0] x, input logic [1:0] y, input int mode);
    if (mode == 2) return 4'd15;
    if (mode == 1 && x == 2'd3 && y == 2'd3) return 4'd7;
    return 4'({2'b00, x} * {2'b00, y});
  endfunction

  always_comb pp_p = pp_fn(pp_a, pp_b, pp_mode);

  // Base-4 long multiplication using the (possibly approximate) digit product.
  function automatic int ref_prod(input int ta, input int tb, input int mode);
    int sum;
    sum = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        sum += int'(pp_fn(2'((ta >> (2 * i)) & 3), 2'((tb >> (2 * j)) & 3), mode)) << (2 * (i + j));
    return sum % (1 << ACC_W);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic accept_run(input int ta, input int tb);
    int e;
    a = 4'(ta);
    b = 4'(tb);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    if (in_done && pend_err && exp_cnt < 255) exp_cnt++;
    in_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("busy_out_valid", 32'(out_valid), 32'd0);
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      chk("pp_a", 32'(pp_a), 32'((ta >> (2 * (k / 2))) & 3));
      chk("pp_b", 32'(pp_b), 32'((tb >> (2 * (k % 2))) & 3));
      a = 4'($urandom);
      b = 4'($urandom);
      in_valid = (k < 3) ? 1'($urandom) : 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    e = ref_prod(ta, tb, pp_mode);
    last_exp = e;
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_p", 32'(p), 32'(e));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_pp", 32'({pp_a, pp_b}), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
    pend_err = (e != ((ta * tb) % (1 << ACC_W)));
`ifdef MULT4_SEQ_CHECK_EN
    chk("err", 32'(err), 32'(pend_err));
    chk("err_cnt_done", 32'(err_cnt), 32'(exp_cnt));
`endif
    in_done = 1'b1;
  endtask

  task automatic drain(input int hold);
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_p", 32'(p), 32'(last_exp));
      chk("hold_busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    if (pend_err && exp_cnt < 255) exp_cnt++;
    in_done = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
`ifdef MULT4_SEQ_CHECK_EN
    chk("err_cnt_after", 32'(err_cnt), 32'(exp_cnt));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pp", 32'({pp_a, pp_b}), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    pp_mode = 0;
    accept_run(3, 5);
    drain(0);
    accept_run(15, 15);
    drain(0);
    accept_run(2, 7);
    accept_run(9, 9);
    drain(0);
    accept_run(6, 4);
    drain(6);

    // Reset while in HL must abandon the transaction.
    a = 4'd5;
    b = 4'd5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("hl_pp_a", 32'(pp_a), 32'd1);
    chk("hl_pp_b", 32'(pp_b), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_pp", 32'({pp_a, pp_b}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_p", 32'(p), 32'd0);
    exp_cnt = 0;
    in_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("postrst_out_valid", 32'(out_valid), 32'd0);
    end
    accept_run(1, 1);
    drain(0);

    pp_mode = 1;
    accept_run(3, 3);
    drain(0);
    pp_mode = 2;
    accept_run(15, 15);
    drain(1);

    for (int i = 0; i < 24; i++) begin
      pp_mode = $urandom_range(0, 2);
      accept_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if (i == 23 || $urandom_range(0, 2) != 0) drain(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
